// File: rtl/mem_stage_if.sv
// mem_stage port bundle: EX->MEM request, MEM->WB result,
// memory read response and the ID bypass bus.
interface mem_stage_if #(
  parameter int EX_TO_MEM_BUS_WD = 108,
  parameter int MEM_TO_WB_BUS_WD = 70,
  parameter int RDW_BUS_WD       = 39
);
  logic                        EX_to_MEM_Valid;
  logic [EX_TO_MEM_BUS_WD-1:0] EX_to_MEM_Bus;
  logic                        MEM_Allow_in;
  logic                        WB_Allow_in;
  logic                        MEM_to_WB_Valid;
  logic [MEM_TO_WB_BUS_WD-1:0] MEM_to_WB_Bus;
  logic [31:0]                 Read_data;
  logic                        Read_data_Valid;
  logic                        Read_data_Ready;
  logic [RDW_BUS_WD-1:0]       rdw_MEM_Bus;

  modport slave (
    input  EX_to_MEM_Valid, EX_to_MEM_Bus, WB_Allow_in,
    input  Read_data, Read_data_Valid,
    output MEM_Allow_in, MEM_to_WB_Valid, MEM_to_WB_Bus,
    output Read_data_Ready, rdw_MEM_Bus
  );

  modport master (
    output EX_to_MEM_Valid, EX_to_MEM_Bus, WB_Allow_in,
    output Read_data, Read_data_Valid,
    input  MEM_Allow_in, MEM_to_WB_Valid, MEM_to_WB_Bus,
    input  Read_data_Ready, rdw_MEM_Bus
  );
endinterface

// File: rtl/mem_stage.sv
// RV32 memory stage: load response wait, byte/half extraction.
// MEM_FORWARD_LOAD_EN lets ID bypass a load once its data arrived.
module mem_stage #(
  parameter int EX_TO_MEM_BUS_WD = 108,
  parameter int MEM_TO_WB_BUS_WD = 70,
  parameter int RDW_BUS_WD       = 39
) (
  input logic       clk,
  input logic       rst,
  mem_stage_if.slave io
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    WAIT  = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_valid;
  logic        r_rdy;
  logic [31:0] r_res;
  logic [31:0] r_pc;
  logic [31:0] r_rdata;
  logic [2:0]  r_f3;
  logic        r_load;
  logic        r_wen;
  logic [4:0]  r_waddr;

  logic        w_allow;
  logic        w_accept;
  logic        w_in_load;
  logic [31:0] w_sh;
  logic [31:0] w_ld;
  logic [31:0] w_value;
  logic        w_vrdy;
  logic        w_unused;

  assign w_in_load = io.EX_to_MEM_Bus[40];
  assign w_allow   = (r_state == EMPTY) |
                     ((r_state == DONE) & io.WB_Allow_in);
  assign w_accept  = io.EX_to_MEM_Valid & w_allow;

  // store data and write-enable belong to EX; only parity-sunk here
  assign w_unused = ^{io.EX_to_MEM_Bus[107:76],
                      io.EX_to_MEM_Bus[39:38]};

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      EMPTY:
        if (w_accept) w_next = w_in_load ? WAIT : DONE;
      WAIT:
        if (io.Read_data_Valid) w_next = DONE;
      DONE:
        if (io.WB_Allow_in)
          w_next = !w_accept ? EMPTY :
                   w_in_load ? WAIT  : DONE;
      default: w_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      r_valid <= 1'b0;
      r_rdy   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_valid <= (w_next == DONE);
      r_rdy   <= (w_next == WAIT);
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_res   <= io.EX_to_MEM_Bus[75:44];
      r_f3    <= io.EX_to_MEM_Bus[43:41];
      r_load  <= io.EX_to_MEM_Bus[40];
      r_wen   <= io.EX_to_MEM_Bus[37];
      r_waddr <= io.EX_to_MEM_Bus[36:32];
      r_pc    <= io.EX_to_MEM_Bus[31:0];
    end
    if ((r_state == WAIT) & io.Read_data_Valid)
      r_rdata <= io.Read_data;
  end

  assign w_sh = r_rdata >> {r_res[1:0], 3'b000};

  always_comb begin
    w_ld = w_sh;
    unique case (r_f3)
      3'b000:  w_ld = {{24{w_sh[7]}}, w_sh[7:0]};
      3'b001:  w_ld = {{16{w_sh[15]}}, w_sh[15:0]};
      3'b100:  w_ld = {24'd0, w_sh[7:0]};
      3'b101:  w_ld = {16'd0, w_sh[15:0]};
      default: w_ld = w_sh;
    endcase
  end

  assign w_value = r_load ? w_ld : r_res;

`ifdef MEM_FORWARD_LOAD_EN
  assign w_vrdy = ~r_load | r_valid;
`else
  assign w_vrdy = ~r_load;
`endif

  assign io.MEM_Allow_in    = w_allow;
  assign io.MEM_to_WB_Valid = r_valid;
  assign io.Read_data_Ready = r_rdy;
  assign io.MEM_to_WB_Bus   = {r_wen, r_waddr, w_value, r_pc};
  assign io.rdw_MEM_Bus     = {w_vrdy,
                               r_wen & (r_state != EMPTY),
                               r_waddr, w_value};

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage of the 5-stage RV32 core, directly downstream of the execute stage. It accepts the execute-to-memory bus, waits for the memory read-response handshake on loads, and aligns and extends the loaded byte, half or word. It forwards the write-back value to the WB stage and publishes a read-during-write bypass bus to ID.

## Interface
Parameters:
- EX_TO_MEM_BUS_WD, 108, width of incoming bus
- MEM_TO_WB_BUS_WD, 70, width of outgoing bus
- RDW_BUS_WD, 39, width of bypass bus

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- EX_to_MEM_Valid  in  1  upstream instruction valid
- EX_to_MEM_Bus  in  108  fields {RF_rdata2[107:76], Result[75:44], funct3[43:41], LOAD[40], STORE[39], MEM_wen[38], WB_wen[37], RF_waddr[36:32], PC[31:0]}
- MEM_Allow_in  out  1  stage can accept this cycle
- WB_Allow_in  in  1  WB stage can accept
- MEM_to_WB_Valid  out  1  result valid to WB
- MEM_to_WB_Bus  out  70  {WB_wen[69], RF_waddr[68:64], WB_value[63:32], PC[31:0]}
- Read_data  in  32  memory read data, word-aligned
- Read_data_Valid  in  1  read response valid
- Read_data_Ready  out  1  stage accepts read response
- rdw_MEM_Bus  out  39  {value_ready[38], wen[37], RF_waddr[36:32], value[31:0]}

## Operation
- FSM states: EMPTY, WAIT (load issued, response pending), DONE (result held for WB).
- Acceptance: when EX_to_MEM_Valid & MEM_Allow_in, latch the bus. Go to WAIT if LOAD, else DONE.
- WAIT: Read_data_Ready=1. On Read_data_Valid, register Read_data and go to DONE. Read_data_Valid in any other state is ignored.
- DONE & WB_Allow_in: the instruction leaves. Go to the next state per acceptance if a new instruction enters the same cycle, else EMPTY.
- MEM_Allow_in = (state==EMPTY) | (state==DONE & WB_Allow_in).
- MEM_to_WB_Valid = (state==DONE).
- Stores need no response: the request completed in EX, so a store goes straight to DONE.
- Load extraction: sh = Read_data >> {Result[1:0],3'b0}.
  - funct3 000: sign-extend sh[7:0]
  - 001: sign-extend sh[15:0]
  - 100: zero-extend sh[7:0]
  - 101: zero-extend sh[15:0]
  - 010 and others: sh (full word)
- WB_value = LOAD ? extracted : Result.
- rdw_MEM_Bus: wen = WB_wen & (state!=EMPTY); value = WB_value; value_ready as per Configuration.

## Timing
- Reset: state EMPTY, MEM_to_WB_Valid=0, Read_data_Ready=0, MEM_Allow_in=1, rdw wen=0. Data registers are not reset.
- Non-load latency: accept at edge N, MEM_to_WB_Valid high in cycle N+1. Full throughput of one instruction per cycle while WB_Allow_in=1.
- Load: Read_data_Ready is high from the cycle after acceptance. The response handshake at edge M makes MEM_to_WB_Valid high in cycle M+1. A response may arrive in the first WAIT cycle.
- WB stall: DONE holds the bus and its outputs stable while WB_Allow_in=0.
- Simultaneous leave and enter in DONE: there is no bubble.
- Reset asserted in WAIT: go to EMPTY. A late response is not accepted because Read_data_Ready=0.
- Unaligned funct3/offset combinations are not checked; extraction follows the shift rule above.

## Configuration
- MEM_FORWARD_LOAD_EN defined: value_ready = ~LOAD | (state==DONE). ID may bypass loaded data from MEM once it has arrived.
- MEM_FORWARD_LOAD_EN undefined: value_ready = ~LOAD. ID must stall on a load in MEM until it reaches WB.

## Test plan
- ADD-type instruction, Result=0x12345678, WB_wen=1, waddr=5 -> MEM_to_WB_Bus next cycle {1,5,0x12345678,PC}, valid for 1 cycle.
- LB, Result[1:0]=3, Read_data=0x80FFFFFF on the second WAIT cycle -> WB_value=0xFFFFFF80, valid in the cycle after the response.
- LHU, Result[1:0]=2, Read_data=0xBEEF1234 -> WB_value=0x0000BEEF. Same case with LH -> 0xFFFFBEEF.
- Hold WB_Allow_in=0 for 3 cycles in DONE with EX_to_MEM_Valid=1 -> MEM_Allow_in=0 and the bus stays stable. Release -> next instruction accepted with no bubble.
- Assert rst in WAIT, then pulse Read_data_Valid -> Read_data_Ready=0, no MEM_to_WB_Valid, state EMPTY.
- Load in DONE under MEM_FORWARD_LOAD_EN -> rdw value_ready=1. Without the macro -> 0.
